lector_temperatura: RTL
=======================

Name: lector_temperatura

Overview:
Upstream stage of the temperature-control block (alarm/fan FSM). It periodically reads a 12-bit serial ADC (16-bit frame, SPI mode 3-like) and scales the result to the 5-bit temperatura code. It presents that code with a one-cycle lect strobe that the control block consumes. en gates sampling so the system can idle the sensor.

Parameters:
CLK_DIV, 25, clock cycles per SCLK half-period (must be >= 2)
SAMPLE_PERIOD, 1000000, clock cycles between conversion start ticks (must be > 34*CLK_DIV)
SHIFT, 7, right shift applied to the 12-bit ADC word before offset
OFFSET, 0, value subtracted after shift (0..31)

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
en  in  1  sampling enable
miso  in  1  ADC serial data
sclk  out  1  ADC serial clock, idles high
cs_n  out  1  ADC chip select, active low
temperatura  out  5  last valid scaled temperature
lect  out  1  one-cycle strobe: temperatura just updated
err_trama  out  1  last frame had non-zero leading bits (sticky until next good frame)
ocupado  out  1  high while a frame is in progress (cs_n low or DONE)

Behaviour:
- Reset: sclk=1, cs_n=1, temperatura=0, lect=0, err_trama=0, ocupado=0, FSM=IDLE, all counters=0. Reset mid-frame aborts the frame immediately; no strobe.
- Tick timer: free-running 0..SAMPLE_PERIOD-1, wraps. The tick is the cycle the counter equals SAMPLE_PERIOD-1. It runs regardless of en.
- FSM states: IDLE, SETUP, SHIFT, HOLD, DONE.
- IDLE -> SETUP on tick && en. cs_n drops in the cycle after the tick. If the FSM is not in IDLE at a tick, that tick is dropped and not queued.
- SETUP: cs_n=0, sclk=1 for CLK_DIV cycles -> SHIFT.
- SHIFT: sclk toggles every CLK_DIV cycles, starting with a falling edge. There are 16 low and 16 high phases. miso is sampled into the shift register, MSB first, in the clock cycle where sclk rises (ADC changes data on the falling edge). After the 16th rising edge, the FSM goes to HOLD.
- HOLD: sclk=1, cs_n=0 for CLK_DIV cycles -> DONE, with cs_n=1 from DONE onward.
- DONE (1 cycle): frame bits[15:12] must all be 0.
  - If they are 0: temperatura <= sat(data[11:0]>>SHIFT - OFFSET) to the range 0..31, lect=1 this cycle, err_trama<=0.
  - If they are not 0: temperatura is held, lect stays 0, err_trama<=1.
  - DONE -> IDLE.
- Arithmetic: compute in 13-bit signed. A negative result gives 0; a result > 31 gives 31.
- en deasserted mid-frame: the frame completes normally, including the strobe. No further frames start.
- lect is never high for two consecutive cycles. temperatura only changes in a lect cycle.
- Frame length from tick to strobe = 1 + CLK_DIV*(1+32+1) + 1 cycles.

Decomposition:
- Shared package: FRAME_BITS=16, DATA_BITS=12, TEMP_BITS=5, and the FSM state encoding (3-bit).
- One natural sub-module: gen_sclk. It holds the half-period counter and the edge counter, and produces sclk, a rise pulse, a fall pulse and a done pulse when enabled. The top module keeps the FSM, timer, shift register and scaling.

Test Plan:
- Use CLK_DIV=2, SAMPLE_PERIOD=100 in all scenarios.
- Reset: hold reset 3 cycles -> sclk=1, cs_n=1, temperatura=0, lect=0, err_trama=0 throughout. No cs_n activity while en=0 across 300 cycles.
- Nominal read:
  - Stimulus: en=1, ADC model drives 0x0C80 (data 3200).
  - Response: 16 rising sclk edges per frame; lect pulses 1 cycle; temperatura=25 (3200>>7).
  - Timing: strobe exactly 70 cycles after the tick; next frame 100 cycles later.
- Saturation: OFFSET=30 with 0x0480 (9-30<0) -> temperatura=0. OFFSET=0 with 0x0FFF -> 31.
- Frame error: ADC drives 0x8C80 -> no lect, err_trama=1, temperatura keeps its previous value 25. A following 0x0500 frame -> lect, temperatura=10, err_trama=0.
- Enable/reset mid-frame:
  - Drop en after the 5th rising sclk edge -> frame completes with lect, then no cs_n for 300 cycles.
  - Separately, assert reset during SHIFT -> next cycle cs_n=1, sclk=1, no lect, temperatura=0.

Source files
------------

// File: rtl/lector_temperatura_pkg.sv
// Shared widths, FSM encoding and the ADC-code-to-temperature scaling for the
// serial temperature reader.
package lector_temperatura_pkg;

  localparam int FRAME_BITS = 16;
  localparam int DATA_BITS  = 12;
  localparam int TEMP_BITS  = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } estado_t;

  // (data >> shift) - offset in 13-bit signed, clamped to 0..31
  function automatic logic [TEMP_BITS-1:0] escalar(input logic [DATA_BITS-1:0] data,
                                                   input int shift, input int offset);
    logic signed [DATA_BITS:0] val;
    val = $signed({1'b0, data >> shift}) - $signed((DATA_BITS+1)'(offset));
    if (val < 0)
      escalar = '0;
    else if (val > 31)
      escalar = 5'd31;
    else
      escalar = val[TEMP_BITS-1:0];
  endfunction

endpackage

// File: rtl/lector_temperatura_gen_sclk.sv
// Serial clock generator: 32 half-periods of CLK_DIV cycles, low phase first.
// Counters are held at zero while disabled, so sclk idles high.
module lector_temperatura_gen_sclk #(
  parameter int CLK_DIV = 25
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall,
  output logic done
);
  import lector_temperatura_pkg::*;

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic [4:0]    fase;
  logic          fin_div;

  assign fin_div = (div_cnt == DIV_MAX);

  always_ff @(posedge clock) begin
    if (reset || !en) begin
      div_cnt <= '0;
      fase    <= '0;
    end else if (fin_div) begin
      div_cnt <= '0;
      fase    <= fase + 5'd1;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // even phases are low, odd phases high
  assign sclk = !en || fase[0];
  assign rise = en && fase[0] && (div_cnt == '0);
  assign fall = en && !fase[0] && (div_cnt == '0);
  assign done = en && (fase == 5'd31) && fin_div;

endmodule

// File: rtl/lector_temperatura.sv
// Periodic 16-bit serial ADC read, scaled to a 5-bit temperature code with a
// one-cycle lect strobe for the downstream control block.
module lector_temperatura #(
  parameter int CLK_DIV       = 25,
  parameter int SAMPLE_PERIOD = 1000000,
  parameter int SHIFT         = 7,
  parameter int OFFSET        = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic       miso,
  output logic       sclk,
  output logic       cs_n,
  output logic [4:0] temperatura,
  output logic       lect,
  output logic       err_trama,
  output logic       ocupado
);
  import lector_temperatura_pkg::*;

  localparam int TW = $clog2(SAMPLE_PERIOD);
  localparam logic [TW-1:0] TICK_MAX = TW'(SAMPLE_PERIOD - 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  estado_t               estado, estado_sig;
  logic [TW-1:0]         tick_cnt;
  logic                  tick;
  logic [DW-1:0]         espera_cnt;
  logic                  fin_espera;
  logic [FRAME_BITS-1:0] trama;
  logic                  sclk_rise, sclk_fall, sclk_done;
  logic                  unused_fall;

  assign tick       = (tick_cnt == TICK_MAX);
  assign fin_espera = (espera_cnt == DIV_MAX);
  assign unused_fall = sclk_fall;

  lector_temperatura_gen_sclk #(.CLK_DIV(CLK_DIV)) u_gen_sclk (
    .clock (clock),
    .reset (reset),
    .en    (estado == ST_SHIFT),
    .sclk  (sclk),
    .rise  (sclk_rise),
    .fall  (sclk_fall),
    .done  (sclk_done)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      estado      <= ST_IDLE;
      tick_cnt    <= '0;
      espera_cnt  <= '0;
      trama       <= '0;
      temperatura <= '0;
      lect        <= 1'b0;
      err_trama   <= 1'b0;
    end else begin
      estado   <= estado_sig;
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      // setup/hold length counter, cleared on every state change
      if ((estado == ST_SETUP || estado == ST_HOLD) && estado_sig == estado)
        espera_cnt <= espera_cnt + DW'(1);
      else
        espera_cnt <= '0;
      // ADC updates on the falling edge, so the rising-edge cycle sees stable data
      if (sclk_rise)
        trama <= {trama[FRAME_BITS-2:0], miso};
      lect <= 1'b0;
      if (estado == ST_DONE) begin
        if (trama[FRAME_BITS-1:DATA_BITS] == '0) begin
          temperatura <= escalar(trama[DATA_BITS-1:0], SHIFT, OFFSET);
          lect        <= 1'b1;
          err_trama   <= 1'b0;
        end else begin
          err_trama   <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    estado_sig = estado;
    case (estado)
      ST_IDLE:  if (tick && en) estado_sig = ST_SETUP;
      ST_SETUP: if (fin_espera) estado_sig = ST_SHIFT;
      ST_SHIFT: if (sclk_done)  estado_sig = ST_HOLD;
      ST_HOLD:  if (fin_espera) estado_sig = ST_DONE;
      ST_DONE:  estado_sig = ST_IDLE;
      default:  estado_sig = ST_IDLE;
    endcase
  end

  assign cs_n    = !(estado == ST_SETUP || estado == ST_SHIFT || estado == ST_HOLD);
  assign ocupado = (estado != ST_IDLE);

endmodule
